// File: rtl/rast_tri_scheduler_if.sv
// Bundle of the scheduler's source, configuration and rasterizer-facing signals.
// The slave modport is the scheduler; the master modport is its environment.
interface rast_tri_scheduler_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri_S;
  logic        [COLORS-1:0][SIGFIG-1:0]          in_color_U;
  logic                                          in_valid;
  logic                                          in_ready;

  logic signed [1:0][SIGFIG-1:0]                 cfg_screen_S;
  logic        [3:0]                             cfg_subSample_U;
  logic                                          cfg_valid;
  logic                                          cfg_ack;

  logic                                          halt_RnnnnL;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U;
  logic                                          validTri_R10H;
  logic signed [1:0][SIGFIG-1:0]                 screen_RnnnnS;
  logic        [3:0]                             subSample_RnnnnU;

  logic                                          busy;
  logic        [31:0]                            tri_count;

  modport slave (
    input  in_tri_S, in_color_U, in_valid,
    output in_ready,
    input  cfg_screen_S, cfg_subSample_U, cfg_valid,
    output cfg_ack,
    input  halt_RnnnnL,
    output tri_R10S, color_R10U, validTri_R10H, screen_RnnnnS, subSample_RnnnnU,
    output busy, tri_count
  );

  modport master (
    output in_tri_S, in_color_U, in_valid,
    input  in_ready,
    output cfg_screen_S, cfg_subSample_U, cfg_valid,
    input  cfg_ack,
    output halt_RnnnnL,
    input  tri_R10S, color_R10U, validTri_R10H, screen_RnnnnS, subSample_RnnnnU,
    input  busy, tri_count
  );
endinterface

// File: rtl/rast_tri_scheduler.sv
// Triangle queue in front of the rasterizer R10 stage; config changes are applied
// only once the queue and the rasterizer pipe have fully drained.
module rast_tri_scheduler #(
  parameter int SIGFIG       = 24,
  parameter int VERTS        = 3,
  parameter int AXIS         = 3,
  parameter int COLORS       = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 10
) (
  input logic                clk,
  input logic                rst,
  rast_tri_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;
  typedef logic signed [1:0][SIGFIG-1:0]                 screen_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN_Q,
    DRAIN_PIPE,
    APPLY
  } state_t;

  state_t state, next_state;

  tri_t    tri_mem   [FIFO_DEPTH];
  color_t  color_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full;

  tri_t        tri_out;
  color_t      color_out;
  logic        valid_out;
  logic [31:0] issue_count;

  logic [CW-1:0] drain_cnt;
  screen_t       screen_pend, screen_act;
  logic [3:0]    sub_pend, sub_act;
  logic          cfg_loaded;

  logic in_ready, push, issue_en, load_out, pop;
  logic latch_cfg, cnt_load, apply_go;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready = (state == RUN) && !full && cfg_loaded;
  assign push     = bus.in_valid && in_ready;
  assign issue_en = (state == RUN) || (state == DRAIN_Q);
  assign load_out = issue_en && bus.halt_RnnnnL;
  assign pop      = load_out && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      tri_mem[wr_ptr[AW-1:0]]   <= bus.in_tri_S;
      color_mem[wr_ptr[AW-1:0]] <= bus.in_color_U;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // R10 output register: frozen while the rasterizer stalls, reloaded otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_out   <= '0;
      color_out <= '0;
      valid_out <= 1'b0;
    end else if (load_out) begin
      valid_out <= !empty;
      if (!empty) begin
        tri_out   <= tri_mem[rd_ptr[AW-1:0]];
        color_out <= color_mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= '0;
    end else if (valid_out && bus.halt_RnnnnL) begin
      issue_count <= issue_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch_cfg  = 1'b0;
    cnt_load   = 1'b0;
    apply_go   = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.cfg_valid) begin
          latch_cfg  = 1'b1;
          next_state = DRAIN_Q;
        end
      end
      DRAIN_Q: begin
        if (empty && !valid_out) begin
          cnt_load   = 1'b1;
          next_state = DRAIN_PIPE;
        end
      end
      DRAIN_PIPE: begin
        if (drain_cnt == '0) begin
          apply_go   = 1'b1;
          next_state = APPLY;
        end
      end
      APPLY: next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // Only stall-free cycles count towards draining the rasterizer pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (cnt_load) begin
      drain_cnt <= CW'(DRAIN_CYCLES);
    end else if ((state == DRAIN_PIPE) && (drain_cnt != '0) && bus.halt_RnnnnL) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      screen_pend <= '0;
      sub_pend    <= '0;
      screen_act  <= '0;
      sub_act     <= '0;
      cfg_loaded  <= 1'b0;
    end else begin
      if (latch_cfg) begin
        screen_pend <= bus.cfg_screen_S;
        sub_pend    <= bus.cfg_subSample_U;
      end
      if (apply_go) begin
        screen_act <= screen_pend;
        sub_act    <= sub_pend;
        cfg_loaded <= 1'b1;
      end
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.cfg_ack          = (state == APPLY);
  assign bus.tri_R10S         = tri_out;
  assign bus.color_R10U       = color_out;
  assign bus.validTri_R10H    = valid_out;
  assign bus.screen_RnnnnS    = screen_act;
  assign bus.subSample_RnnnnU = sub_act;
  assign bus.busy             = (state != RUN) || !empty || valid_out;
  assign bus.tri_count        = issue_count;
endmodule

// File: tb/tb_rast_tri_scheduler.sv
// Scoreboard bench for rast_tri_scheduler: directed scenarios plus random traffic,
// checked against a queue-level model of ordering, config timing and stalls.
module tb_rast_tri_scheduler;
  localparam int SIGFIG = 24, VERTS = 3, AXIS = 3, COLORS = 3;
  localparam int DEPTH = 4, DRAIN = 10;
  localparam int TRI_W = SIGFIG * VERTS * AXIS;
  localparam int COL_W = SIGFIG * COLORS;
  localparam int SCR_W = SIGFIG * 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rast_tri_scheduler_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

  rast_tri_scheduler #(
    .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
    .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [TRI_W-1:0] t;
    logic [COL_W-1:0] c;
    logic [SCR_W-1:0] scr;
    logic [3:0]       sub;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit               in_progress;
  bit               m_loaded;
  int               stage;
  int               gated;
  logic [31:0]      m_cnt;
  logic [SCR_W-1:0] app_scr, pend_scr;
  logic [3:0]       app_sub, pend_sub;
  bit               hold_chk;
  logic [TRI_W-1:0] hold_tri;
  logic [COL_W-1:0] hold_col;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TRI_W-1:0] rnd_tri();
    logic [TRI_W-1:0] v = '0;
    for (int i = 0; i < (TRI_W + 31) / 32; i++) v = (v << 32) | TRI_W'($urandom());
    return v;
  endfunction

  function automatic logic [COL_W-1:0] rnd_col();
    logic [COL_W-1:0] v = '0;
    for (int i = 0; i < (COL_W + 31) / 32; i++) v = (v << 32) | COL_W'($urandom());
    return v;
  endfunction

  // Config rule of thumb: the queue must empty, then one cycle, DRAIN halt-high
  // cycles of pipe drain, one more cycle, and the ack shows with the new config.
  always @(negedge clk) begin
    int  occ0;
    bit  ip0;
    exp_t e;
    if (rst) begin
      chk("rst_valid", bus.validTri_R10H, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_count", bus.tri_count, 32'd0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_ack", bus.cfg_ack, 1'b0);
      chk("rst_screen", $unsigned(bus.screen_RnnnnS), '0);
      chk("rst_sub", bus.subSample_RnnnnU, 4'd0);
      exp_q.delete();
      in_progress = 0; m_loaded = 0; stage = 0; gated = 0; m_cnt = '0;
      app_scr = '0; app_sub = '0; pend_scr = '0; pend_sub = '0; hold_chk = 0;
    end else begin
      occ0 = exp_q.size();
      ip0  = in_progress;
      chk("busy", bus.busy, ip0 || (occ0 != 0));
      chk("tri_count", bus.tri_count, m_cnt);
      chk("cfg_ack", bus.cfg_ack, stage == 2);
      chk("screen", $unsigned(bus.screen_RnnnnS), (stage == 2) ? pend_scr : app_scr);
      chk("subsample", bus.subSample_RnnnnU, (stage == 2) ? pend_sub : app_sub);
      if (!m_loaded || ip0) chk("in_ready_closed", bus.in_ready, 1'b0);
      else if (occ0 < DEPTH) chk("in_ready_open", bus.in_ready, 1'b1);
      if (hold_chk) begin
        chk("hold_valid", bus.validTri_R10H, 1'b1);
        chk("hold_tri", $unsigned(bus.tri_R10S), hold_tri);
        chk("hold_color", bus.color_R10U, hold_col);
      end
      hold_chk = bus.validTri_R10H && !bus.halt_RnnnnL;
      hold_tri = $unsigned(bus.tri_R10S);
      hold_col = bus.color_R10U;

      if (bus.validTri_R10H && bus.halt_RnnnnL) begin
        if (exp_q.size() == 0) begin
          chk("issue_spurious", bus.validTri_R10H, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("issue_tri", $unsigned(bus.tri_R10S), e.t);
          chk("issue_color", bus.color_R10U, e.c);
          chk("issue_screen", $unsigned(bus.screen_RnnnnS), e.scr);
          chk("issue_sub", bus.subSample_RnnnnU, e.sub);
          m_cnt = m_cnt + 32'd1;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.t = $unsigned(bus.in_tri_S); e.c = bus.in_color_U; e.scr = app_scr; e.sub = app_sub;
        exp_q.push_back(e);
      end

      if (stage == 2) begin
        app_scr = pend_scr; app_sub = pend_sub; m_loaded = 1; in_progress = 0; stage = 0;
      end else if (stage == 1) begin
        if (gated == 0) stage = 2;
        else if (bus.halt_RnnnnL) gated--;
      end else if (ip0 && occ0 == 0) begin
        stage = 1; gated = DRAIN;
      end
      if (!ip0 && bus.cfg_valid) begin
        in_progress = 1;
        pend_scr = $unsigned(bus.cfg_screen_S);
        pend_sub = bus.cfg_subSample_U;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_tri();
    bit ok = 0;
    bus.in_valid   = 1'b1;
    bus.in_tri_S   = rnd_tri();
    bus.in_color_U = rnd_col();
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_ack(output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = bus.cfg_ack;
      if (!got) begin tick(); lat++; end
    end
    chk("ack_seen", got, 1'b1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [SCR_W-1:0] scr, input logic [3:0] sub, output int lat);
    bus.cfg_screen_S    = scr;
    bus.cfg_subSample_U = sub;
    bus.cfg_valid       = 1'b1;
    wait_ack(lat);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 500 && !idle; i++) begin
      tick();
      idle = (exp_q.size() == 0) && !in_progress;
    end
    chk("idle_reached", idle, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    bus.in_valid = 0; bus.in_tri_S = '0; bus.in_color_U = '0;
    bus.cfg_valid = 0; bus.cfg_screen_S = '0; bus.cfg_subSample_U = '0;
    bus.halt_RnnnnL = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // refused before first config; first config latency
    bus.in_valid = 1'b1; bus.in_tri_S = rnd_tri(); bus.in_color_U = rnd_col();
    repeat (3) tick();
    bus.in_valid = 1'b0;
    do_cfg({24'd1024, 24'd1024}, 4'b0100, lat);
    chk("first_cfg_latency", lat, DRAIN + 3);
    chk("first_cfg_screen", $unsigned(bus.screen_RnnnnS), {24'd1024, 24'd1024});

    // back-to-back stream
    repeat (4) push_tri();
    wait_idle();

    // fill queue plus output register under stall
    push_tri();
    repeat (2) tick();
    bus.halt_RnnnnL = 1'b0;
    repeat (4) push_tri();
    bus.in_valid = 1'b1; bus.in_tri_S = rnd_tri();
    repeat (10) tick();
    bus.in_valid = 1'b0;
    bus.halt_RnnnnL = 1'b1;
    wait_idle();

    // config raised alongside the third push
    push_tri();
    push_tri();
    bus.cfg_screen_S = {24'd640, 24'd480}; bus.cfg_subSample_U = 4'b0010; bus.cfg_valid = 1'b1;
    push_tri();
    wait_ack(lat);
    chk("cfg4_screen", $unsigned(bus.screen_RnnnnS), {24'd640, 24'd480});
    wait_idle();

    // stall during pipe drain delays the ack one-for-one
    fork
      do_cfg({24'd800, 24'd600}, 4'b1000, lat);
      begin
        repeat (4) tick();
        bus.halt_RnnnnL = 1'b0;
        repeat (5) tick();
        bus.halt_RnnnnL = 1'b1;
      end
    join
    chk("stall_cfg_latency", lat, DRAIN + 3 + 5);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      bit a;
      @(negedge clk);
      a = bus.cfg_ack;
      tick();
      if (bus.cfg_valid && a) bus.cfg_valid = 1'b0;
      else if (!bus.cfg_valid && ($urandom_range(49) == 0)) begin
        bus.cfg_screen_S    = SCR_W'({$urandom(), $urandom()});
        bus.cfg_subSample_U = 4'($urandom());
        bus.cfg_valid       = 1'b1;
      end
      bus.in_valid    = ($urandom_range(9) < 6);
      bus.in_tri_S    = rnd_tri();
      bus.in_color_U  = rnd_col();
      bus.halt_RnnnnL = ($urandom_range(9) < 7);
    end
    bus.in_valid = 1'b0;
    bus.halt_RnnnnL = 1'b1;
    if (bus.cfg_valid) wait_ack(lat);
    wait_idle();

    // reset in the middle of a queue drain
    bus.halt_RnnnnL = 1'b0;
    push_tri();
    push_tri();
    bus.cfg_screen_S = {24'd320, 24'd240}; bus.cfg_subSample_U = 4'b0001; bus.cfg_valid = 1'b1;
    repeat (3) tick();
    #3 rst = 1'b1;
    bus.cfg_valid = 1'b0;
    tick();
    rst = 1'b0;
    bus.halt_RnnnnL = 1'b1;
    bus.in_valid = 1'b1; bus.in_tri_S = rnd_tri(); bus.in_color_U = rnd_col();
    repeat (3) tick();
    bus.in_valid = 1'b0;
    do_cfg({24'd1024, 24'd768}, 4'b0100, lat);
    chk("post_rst_cfg_latency", lat, DRAIN + 3);
    repeat (3) push_tri();
    wait_idle();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
